// File: rtl/button_press_classifier.sv
// ---------------------------------------------------------------------------
// button_press_classifier
//   Turns the debounced button level into single-cycle event pulses:
//   Press, Release, Short, LongPress and auto-Repeat. Held is a level that is
//   high while a press is in progress. All outputs are registered, so each
//   pulse appears in the cycle after the edge that makes the decision.
// ---------------------------------------------------------------------------
module button_press_classifier #(
    parameter int   LONG_CYCLES   = 1000,
    parameter int   REPEAT_CYCLES = 200,
    parameter logic REPEAT_EN     = 1'b1,
    parameter int   CNT_W         = 16
) (
    input  logic Clk,
    input  logic Rst,
    input  logic In,
    output logic Press,
    output logic Release,
    output logic Short,
    output logic LongPress,
    output logic Repeat,
    output logic Held
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } state_t;

    // Terminal count values: the threshold fires on the edge where Count
    // already holds N-1 and In is still high.
    localparam logic [CNT_W-1:0] LONG_LAST_C   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST_C = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO_C    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_s;
    logic             prev_r;

    logic press_s;
    logic release_s;
    logic short_s;
    logic long_s;
    logic repeat_s;
    logic held_s;

    logic press_r;
    logic release_r;
    logic short_r;
    logic long_r;
    logic repeat_r;
    logic held_r;

    // Next-state, next-count and next-output decode for the press FSM.
    always_comb begin
        state_s   = state_r;
        count_s   = count_r;
        press_s   = 1'b0;
        release_s = 1'b0;
        short_s   = 1'b0;
        long_s    = 1'b0;
        repeat_s  = 1'b0;
        held_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // Rising edge only: a level held through reset (Prev=1) is ignored.
                if (In && !prev_r) begin
                    press_s = 1'b1;
                    state_s = ST_PRESSED;
                    count_s = CNT_ONE_C;
                end else begin
                    count_s = CNT_ZERO_C;
                end
            end

            ST_PRESSED: begin
                // Release is checked first so it wins over the long threshold.
                if (!In) begin
                    release_s = 1'b1;
                    short_s   = 1'b1;
                    state_s   = ST_IDLE;
                    count_s   = CNT_ZERO_C;
                end else if (count_r == LONG_LAST_C) begin
                    long_s  = 1'b1;
                    state_s = ST_LONG;
                    count_s = CNT_ZERO_C;
                end else begin
                    count_s = count_r + CNT_ONE_C;
                end
            end

            ST_LONG: begin
                // Release again has priority over the repeat threshold.
                if (!In) begin
                    release_s = 1'b1;
                    state_s   = ST_IDLE;
                    count_s   = CNT_ZERO_C;
                end else if (count_r == REPEAT_LAST_C) begin
                    repeat_s = REPEAT_EN;
                    count_s  = CNT_ZERO_C;
                end else begin
                    count_s = count_r + CNT_ONE_C;
                end
            end

            default: begin
                state_s = ST_IDLE;
                count_s = CNT_ZERO_C;
            end
        endcase

        held_s = (state_s != ST_IDLE);
    end

    // State, counter, previous-level and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r   <= ST_IDLE;
            count_r   <= CNT_ZERO_C;
            prev_r    <= 1'b1;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            short_r   <= 1'b0;
            long_r    <= 1'b0;
            repeat_r  <= 1'b0;
            held_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            count_r   <= count_s;
            prev_r    <= In;
            press_r   <= press_s;
            release_r <= release_s;
            short_r   <= short_s;
            long_r    <= long_s;
            repeat_r  <= repeat_s;
            held_r    <= held_s;
        end
    end

    assign Press     = press_r;
    assign Release   = release_r;
    assign Short     = short_r;
    assign LongPress = long_r;
    assign Repeat    = repeat_r;
    assign Held      = held_r;

endmodule

// File: tb/tb_button_press_classifier.sv
// ---------------------------------------------------------------------------
// tb_button_press_classifier
//   Directed bench. Two instances share the same stimulus: one with Repeat
//   enabled, one with it disabled (whose expected Repeat is always 0).
//   Output vectors are packed as {Press, Release, Short, LongPress, Repeat, Held}.
// ---------------------------------------------------------------------------
module tb_button_press_classifier;

    localparam int L_C = 8;
    localparam int R_C = 4;

    localparam logic [5:0] E_NONE      = 6'b000000;
    localparam logic [5:0] E_PRESS     = 6'b100001;
    localparam logic [5:0] E_HELD      = 6'b000001;
    localparam logic [5:0] E_REL_SHORT = 6'b011000;
    localparam logic [5:0] E_REL       = 6'b010000;
    localparam logic [5:0] E_LONG      = 6'b000101;
    localparam logic [5:0] E_REP       = 6'b000011;
    localparam logic [5:0] NOREP_MASK  = 6'b111101;

    logic Clk;
    logic Rst;
    logic In;

    logic press_a, release_a, short_a, long_a, repeat_a, held_a;
    logic press_b, release_b, short_b, long_b, repeat_b, held_b;

    int checks;
    int errors;

    button_press_classifier #(
        .LONG_CYCLES   (L_C),
        .REPEAT_CYCLES (R_C),
        .REPEAT_EN     (1'b1),
        .CNT_W         (16)
    ) dut_rep (
        .Clk       (Clk),
        .Rst       (Rst),
        .In        (In),
        .Press     (press_a),
        .Release   (release_a),
        .Short     (short_a),
        .LongPress (long_a),
        .Repeat    (repeat_a),
        .Held      (held_a)
    );

    button_press_classifier #(
        .LONG_CYCLES   (L_C),
        .REPEAT_CYCLES (R_C),
        .REPEAT_EN     (1'b0),
        .CNT_W         (16)
    ) dut_norep (
        .Clk       (Clk),
        .Rst       (Rst),
        .In        (In),
        .Press     (press_b),
        .Release   (release_b),
        .Short     (short_b),
        .LongPress (long_b),
        .Repeat    (repeat_b),
        .Held      (held_b)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check_val(input string tag, input logic [5:0] obs, input logic [5:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    // Apply one input sample, clock it, then check both instances.
    task automatic step(input logic in_v, input logic rst_v, input logic [5:0] exp_v, input string tag);
        In  = in_v;
        Rst = rst_v;
        @(posedge Clk);
        #1;
        check_val(tag, {press_a, release_a, short_a, long_a, repeat_a, held_a}, exp_v);
        check_val({tag, "_norep"}, {press_b, release_b, short_b, long_b, repeat_b, held_b},
                  exp_v & NOREP_MASK);
    endtask

    function automatic logic [5:0] long_hold_exp(input int e);
        if (e == 1)
            return E_PRESS;
        else if (e == L_C)
            return E_LONG;
        else if (e > L_C && ((e - L_C) % R_C) == 0)
            return E_REP;
        else
            return E_HELD;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        In     = 1'b0;
        Rst    = 1'b1;
        @(negedge Clk);

        // Reset state, then one low sample so Prev becomes 0.
        step(1'b0, 1'b1, E_NONE, "rst0");
        step(1'b0, 1'b1, E_NONE, "rst1");
        step(1'b0, 1'b0, E_NONE, "idle0");

        // 1. Short press: 3 highs, then release with Short.
        step(1'b1, 1'b0, E_PRESS,     "t1_press");
        step(1'b1, 1'b0, E_HELD,      "t1_held2");
        step(1'b1, 1'b0, E_HELD,      "t1_held3");
        step(1'b0, 1'b0, E_REL_SHORT, "t1_rel");

        // Back-to-back: press in the cycle right after Release.
        step(1'b1, 1'b0, E_PRESS,     "b2b_press");
        step(1'b0, 1'b0, E_REL_SHORT, "b2b_rel");
        step(1'b0, 1'b0, E_NONE,      "b2b_idle");

        // 2. Long press with repeat: 20 highs, then release without Short.
        for (int e = 1; e <= 20; e++)
            step(1'b1, 1'b0, long_hold_exp(e), $sformatf("t2_e%0d", e));
        step(1'b0, 1'b0, E_REL,  "t2_rel");
        step(1'b0, 1'b0, E_NONE, "t2_idle");

        // 3. Threshold race: release on the edge that would fire LongPress.
        for (int e = 1; e <= L_C - 1; e++)
            step(1'b1, 1'b0, (e == 1) ? E_PRESS : E_HELD, $sformatf("t3_e%0d", e));
        step(1'b0, 1'b0, E_REL_SHORT, "t3_rel");
        step(1'b0, 1'b0, E_NONE,      "t3_idle");

        // 4. Held through reset: nothing until released and pressed again.
        step(1'b1, 1'b1, E_NONE, "t4_rst");
        for (int e = 1; e <= 15; e++)
            step(1'b1, 1'b0, E_NONE, $sformatf("t4_hold%0d", e));
        step(1'b0, 1'b0, E_NONE,      "t4_drop");
        step(1'b1, 1'b0, E_PRESS,     "t4_repress");
        step(1'b0, 1'b0, E_REL_SHORT, "t4_rel");
        step(1'b0, 1'b0, E_NONE,      "t4_idle");

        // 5. Reset mid-LONG: outputs clear, no Release afterwards.
        for (int e = 1; e <= 10; e++)
            step(1'b1, 1'b0, long_hold_exp(e), $sformatf("t5_e%0d", e));
        step(1'b1, 1'b1, E_NONE, "t5_rst");
        step(1'b1, 1'b0, E_NONE, "t5_post1");
        step(1'b1, 1'b0, E_NONE, "t5_post2");
        step(1'b0, 1'b0, E_NONE, "t5_drop");
        step(1'b0, 1'b0, E_NONE, "t5_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
